pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit. Merges per-stage stall requests into a thermometer stall vector. Sequences multi-cycle pipeline flushes carrying a redirect PC. Adds stall-timeout detection and a stall performance counter. Sits beside the pipeline stages and drives every stage register's stall/flush inputs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl_stall_mask_gen.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

  localparam logic RESET_ACTIVE = 1'b1;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the pipeline stages (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) ();

  logic [NSTAGE-1:0] stallreq;
  logic              flush_req;
  logic [ADDR_W-1:0] flush_pc;
  logic              err_clr;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              new_pc_valid;
  logic              busy_flush;
  logic              timeout_err;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output stallreq, flush_req, flush_pc, err_clr,
    input  stall, flush, new_pc, new_pc_valid, busy_flush, timeout_err, stall_cycles
  );

  modport slave (
    input  stallreq, flush_req, flush_pc, err_clr,
    output stall, flush, new_pc, new_pc_valid, busy_flush, timeout_err, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_stall_mask_gen.sv
// Turns per-stage stall requests into a thermometer mask: every stage at or
// below the highest requesting stage is stalled.
module stall_mask_gen #(
  parameter int NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] req,
  output logic [NSTAGE-1:0] mask
);

  logic acc_s;

  // Running OR from the last stage down to the PC stage.
  always_comb begin
    acc_s = 1'b0;
    mask  = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc_s   = acc_s | req[i];
      mask[i] = acc_s;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: thermometer stall merge, multi-cycle flush sequencing
// with redirect PC, stall-timeout detection and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE        = 6,
  parameter int ADDR_W        = 32,
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int RUN_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam int FC_W  = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [RUN_W-1:0] TO_LIM     = RUN_W'(STALL_TIMEOUT - 1);
  localparam logic             TIMEOUT_EN = (STALL_TIMEOUT != 0);

  ctrl_state_e       state_r;
  logic [FC_W-1:0]   fcnt_r;
  logic              flush_r;
  logic              busy_r;
  logic              npv_r;
  logic [ADDR_W-1:0] new_pc_r;
  logic [RUN_W-1:0]  run_len_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic [NSTAGE-1:0] mask_s;
  logic [NSTAGE-1:0] stall_s;
  logic              stall_any_s;
  logic              timeout_hit_s;

  stall_mask_gen #(.NSTAGE(NSTAGE)) u_mask (
    .req  (bus.stallreq),
    .mask (mask_s)
  );

  // Stall is zero-latency; a same-cycle flush request or reset overrides it.
  always_comb begin
    stall_s = '0;
    if (rst == RESET_ACTIVE) begin
      stall_s = '0;
    end else begin
      case (state_r)
        RUN:     stall_s = bus.flush_req ? '0 : mask_s;
        FLUSH:   stall_s = '0;
        default: stall_s = '0;
      endcase
    end
  end

  // The current cycle completes the timeout run when run_len_r already holds
  // STALL_TIMEOUT-1 previous stalled cycles.
  always_comb begin
    stall_any_s = |stall_s;
    if (TIMEOUT_EN && stall_any_s && (run_len_r >= TO_LIM)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Flush sequencer with registered flush/busy/new_pc_valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET_ACTIVE) begin
      state_r  <= RUN;
      fcnt_r   <= '0;
      flush_r  <= 1'b0;
      busy_r   <= 1'b0;
      npv_r    <= 1'b0;
      new_pc_r <= '0;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.flush_req) begin
            state_r  <= FLUSH;
            fcnt_r   <= FC_LAST;
            flush_r  <= 1'b1;
            busy_r   <= 1'b1;
            npv_r    <= 1'b1;
            new_pc_r <= bus.flush_pc;
          end else begin
            flush_r <= 1'b0;
            busy_r  <= 1'b0;
            npv_r   <= 1'b0;
          end
        end
        FLUSH: begin
          npv_r <= 1'b0;
          if (fcnt_r == '0) begin
            state_r <= RUN;
            flush_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            fcnt_r <= fcnt_r - FC_W'(1);
          end
        end
        default: begin
          state_r <= RUN;
          fcnt_r  <= '0;
          flush_r <= 1'b0;
          busy_r  <= 1'b0;
          npv_r   <= 1'b0;
        end
      endcase
    end
  end

  // Stall run length, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET_ACTIVE) begin
      run_len_r   <= '0;
      timeout_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      if (stall_any_s) begin
        if (!(&run_len_r)) begin
          run_len_r <= run_len_r + RUN_W'(1);
        end else begin
          run_len_r <= run_len_r;
        end
      end else begin
        run_len_r <= '0;
      end

      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end else if (bus.err_clr) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end

      if (stall_any_s && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.stall        = stall_s;
  assign bus.flush        = flush_r;
  assign bus.busy_flush   = busy_r;
  assign bus.new_pc_valid = npv_r;
  assign bus.new_pc       = new_pc_r;
  assign bus.timeout_err  = timeout_r;
  assign bus.stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all checked every cycle against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int NSTAGE = 6;
  localparam int ADDR_W = 32;
  localparam int FLUSH_CYCLES = 3;
  localparam int STALL_TIMEOUT = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .NSTAGE(NSTAGE), .ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES),
    .STALL_TIMEOUT(STALL_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_fl_left;
  bit          m_first;
  logic [31:0] m_pc;
  int          m_run;
  bit          m_to;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NSTAGE-1:0] therm(input logic [NSTAGE-1:0] r);
    int h;
    logic [NSTAGE-1:0] m;
    h = -1;
    m = '0;
    for (int i = 0; i < NSTAGE; i++) if (r[i]) h = i;
    for (int i = 0; i < NSTAGE; i++) if (i <= h) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [NSTAGE-1:0] exp_stall();
    if (m_fl_left > 0 || bus.flush_req) return '0;
    return therm(bus.stallreq);
  endfunction

  task automatic model_reset();
    m_fl_left = 0; m_first = 0; m_pc = '0; m_run = 0; m_to = 0; m_cnt = 0;
  endtask

  task automatic check_all();
    check_eq("stall",        64'(bus.stall),        64'(exp_stall()));
    check_eq("flush",        64'(bus.flush),        64'(m_fl_left > 0));
    check_eq("busy_flush",   64'(bus.busy_flush),   64'(m_fl_left > 0));
    check_eq("new_pc_valid", 64'(bus.new_pc_valid), 64'(m_first));
    check_eq("new_pc",       64'(bus.new_pc),       64'(m_pc));
    check_eq("timeout_err",  64'(bus.timeout_err),  64'(m_to));
    check_eq("stall_cycles", 64'(bus.stall_cycles), 64'(m_cnt));
  endtask

  task automatic model_update();
    bit nz;
    nz = (exp_stall() != '0);
    if (nz && (m_run + 1 >= STALL_TIMEOUT) && STALL_TIMEOUT != 0) m_to = 1;
    else if (bus.err_clr) m_to = 0;
    m_run = nz ? ((m_run < 1000000) ? m_run + 1 : m_run) : 0;
    if (nz && m_cnt < CNT_MAX) m_cnt++;
    if (m_fl_left > 0) begin
      m_fl_left--;
      m_first = 0;
    end else if (bus.flush_req) begin
      m_fl_left = FLUSH_CYCLES;
      m_first = 1;
      m_pc = bus.flush_pc;
    end
  endtask

  task automatic step(input logic [NSTAGE-1:0] sr, input logic fr,
                      input logic [31:0] fpc, input logic ec);
    @(posedge clk);
    #1;
    bus.stallreq = sr; bus.flush_req = fr; bus.flush_pc = fpc; bus.err_clr = ec;
    @(negedge clk);
    check_all();
    model_update();
  endtask

  // Asynchronous reset asserted mid-cycle with stall requests still active.
  task automatic do_reset();
    @(posedge clk);
    #3;
    bus.stallreq = 6'b111111;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_stall",  64'(bus.stall),        64'd0);
    check_eq("rst_flush",  64'(bus.flush),        64'd0);
    check_eq("rst_npv",    64'(bus.new_pc_valid), 64'd0);
    check_eq("rst_newpc",  64'(bus.new_pc),       64'd0);
    check_eq("rst_busy",   64'(bus.busy_flush),   64'd0);
    check_eq("rst_to",     64'(bus.timeout_err),  64'd0);
    check_eq("rst_cnt",    64'(bus.stall_cycles), 64'd0);
    bus.stallreq = '0; bus.flush_req = 1'b0; bus.flush_pc = '0; bus.err_clr = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [NSTAGE-1:0] sr;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.stallreq = '0; bus.flush_req = 1'b0; bus.flush_pc = '0; bus.err_clr = 1'b0;
    model_reset();
    do_reset();

    // Thermometer merge and stall counting
    step(6'b000100, 1'b0, 32'h0, 1'b0);
    check_eq("therm_a", 64'(bus.stall), 64'h07);
    step(6'b001000, 1'b0, 32'h0, 1'b0);
    check_eq("therm_b", 64'(bus.stall), 64'h0F);
    step(6'b001100, 1'b0, 32'h0, 1'b0);
    step(6'b000000, 1'b0, 32'h0, 1'b0);
    check_eq("cnt3", 64'(bus.stall_cycles), 64'd3);

    // Flush with redirect PC while a stall is requested, then full stall
    step(6'b001000, 1'b1, 32'h8000_0040, 1'b0);
    check_eq("flush_kills_stall", 64'(bus.stall), 64'd0);
    for (int i = 0; i < 5; i++) step(6'b111111, 1'b0, 32'h0, 1'b0);
    check_eq("post_flush_stall", 64'(bus.stall), 64'h3F);
    check_eq("redirect_pc", 64'(bus.new_pc), 64'h8000_0040);

    // Timeout: sticky after the 4th consecutive stall, cleared by err_clr
    do_reset();
    for (int i = 0; i < 6; i++) step(6'b000010, 1'b0, 32'h0, 1'b0);
    check_eq("timeout_set", 64'(bus.timeout_err), 64'd1);
    step(6'b000000, 1'b0, 32'h0, 1'b0);
    step(6'b000000, 1'b0, 32'h0, 1'b1);
    step(6'b000000, 1'b0, 32'h0, 1'b0);
    check_eq("timeout_clr", 64'(bus.timeout_err), 64'd0);

    // Reset in the second FLUSH cycle abandons the redirect
    step(6'b000000, 1'b1, 32'h1234_5678, 1'b0);
    step(6'b000000, 1'b0, 32'h0, 1'b0);
    do_reset();
    step(6'b000001, 1'b0, 32'h0, 1'b0);
    check_eq("post_rst_stall", 64'(bus.stall), 64'h01);
    step(6'b000000, 1'b0, 32'h0, 1'b0);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) step(6'b100000, 1'b0, 32'h0, 1'b0);
    check_eq("cnt_sat", 64'(bus.stall_cycles), 64'd15);

    // Random traffic
    do_reset();
    sr = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      if ($urandom_range(3) == 0) sr = ($urandom_range(1) == 0) ? '0 : NSTAGE'($urandom);
      step(sr, ($urandom_range(9) == 0), $urandom, ($urandom_range(15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
